// File: rtl/sort_pkg.sv
// Shared definitions for the sort scheduler: FSM state encoding, default
// geometry, the compare-count helper and the element type.
package sort_pkg;

   localparam int N_DEF = 5;
   localparam int W_DEF = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SORT = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic [W_DEF-1:0] elem_t;

   // Number of compare-exchange steps in a full bubble-sort schedule.
   function automatic int num_cmp(input int n);
      return n * (n - 1) / 2;
   endfunction

endpackage

// File: rtl/cmp_swap.sv
// Combinational compare-exchange cell.
//   a, b     : operands (a sits at the lower vector position)
//   desc     : 0 ascending, 1 descending
//   lo_out   : value written back to the lower position
//   hi_out   : value written back to the upper position
//   swapped  : high when the operands were exchanged
// Equal operands never swap, which keeps the sort stable.
module cmp_swap
   import sort_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         desc,
   output logic [W-1:0] lo_out,
   output logic [W-1:0] hi_out,
   output logic         swapped
);

   assign swapped = desc ? (a < b) : (a > b);
   assign lo_out  = swapped ? b : a;
   assign hi_out  = swapped ? a : b;

endmodule

// File: rtl/sort_sched_ctrl.sv
// Sequential bubble-sort scheduler. Accepts one N-element vector, sorts it
// in place with a single shared compare-exchange cell (one step per cycle,
// fixed schedule of num_cmp(N) steps), then presents the sorted vector, its
// median and the number of exchanges until the consumer accepts.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake; in_ready high only in IDLE
//   in_data, in_desc    : vector (element k at [k*W +: W]) and order select
//   out_valid/out_ready : output handshake; result held until accepted
//   out_sorted          : sorted vector, element 0 at [W-1:0]
//   out_median          : element N/2 of out_sorted
//   swap_cnt            : exchanges performed for this vector
//   busy                : high while sorting
//
// state | meaning
// IDLE  | waiting for an input vector, in_ready high
// SORT  | one compare-exchange per cycle on reg[idx], reg[idx+1]
// DONE  | result presented, waiting for out_ready
module sort_sched_ctrl
   import sort_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = W_DEF
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [N*W-1:0]                      in_data,
   input  logic                                in_desc,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [N*W-1:0]                      out_sorted,
   output logic [W-1:0]                        out_median,
   output logic [$clog2(num_cmp(N)+1)-1:0]     swap_cnt,
   output logic                                busy
);

   localparam int NUM_CMP = num_cmp(N);
   localparam int CW      = $clog2(NUM_CMP + 1);
   localparam int IW      = $clog2(N);

   state_t          state_q, state_d;
   logic [W-1:0]    elem_q  [N];
   logic [W-1:0]    elem_wb [N];
   logic [N*W-1:0]  elem_wb_flat;
   logic            desc_q;
   logic [IW-1:0]   idx_q, pass_q;
   logic [IW-1:0]   idx_p1, idx_end;
   logic [CW-1:0]   swap_cnt_q;
   logic [N*W-1:0]  out_sorted_q;
   logic [W-1:0]    out_median_q;
   logic [W-1:0]    op_a, op_b, lo_val, hi_val;
   logic            swapped;
   logic            last_cmp;

   assign idx_p1   = idx_q + IW'(1);
   // Each pass shrinks by one because the largest (or smallest) element has
   // bubbled to the top of the unsorted region.
   assign idx_end  = IW'(N - 2) - pass_q;
   assign last_cmp = (pass_q == IW'(N - 2)) && (idx_q == '0);

   assign op_a = elem_q[idx_q];
   assign op_b = elem_q[idx_p1];

   cmp_swap #(.W(W)) u_cmp (
      .a       (op_a),
      .b       (op_b),
      .desc    (desc_q),
      .lo_out  (lo_val),
      .hi_out  (hi_val),
      .swapped (swapped)
   );

   // Vector as it will look after this cycle's compare-exchange.
   always_comb begin
      elem_wb = elem_q;
      elem_wb[idx_q]  = lo_val;
      elem_wb[idx_p1] = hi_val;
   end

   always_comb begin
      elem_wb_flat = '0;
      for (int k = 0; k < N; k++) begin
         elem_wb_flat[k*W +: W] = elem_wb[k];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = SORT;
            end
         end
         SORT: begin
            busy = 1'b1;
            if (last_cmp) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         elem_q       <= '{default: '0};
         desc_q       <= 1'b0;
         idx_q        <= '0;
         pass_q       <= '0;
         swap_cnt_q   <= '0;
         out_sorted_q <= '0;
         out_median_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  for (int k = 0; k < N; k++) begin
                     elem_q[k] <= in_data[k*W +: W];
                  end
                  desc_q     <= in_desc;
                  swap_cnt_q <= '0;
                  idx_q      <= '0;
                  pass_q     <= '0;
               end
            end
            SORT: begin
               elem_q <= elem_wb;
               if (swapped) begin
                  swap_cnt_q <= swap_cnt_q + CW'(1);
               end
               if (idx_q == idx_end) begin
                  idx_q  <= '0;
                  pass_q <= pass_q + IW'(1);
               end else begin
                  idx_q <= idx_p1;
               end
               // Result registers load on the final step so they are
               // already valid in the first DONE cycle.
               if (last_cmp) begin
                  out_sorted_q <= elem_wb_flat;
                  out_median_q <= elem_wb[N/2];
               end
            end
            default: ;
         endcase
      end
   end

   assign out_sorted = out_sorted_q;
   assign out_median = out_median_q;
   assign swap_cnt   = swap_cnt_q;

endmodule

// File: doc/sort_sched_ctrl.md
Name: sort_sched_ctrl

Overview:
- Sequential sort scheduler: accepts one N-element vector over a valid/ready handshake, then sorts it in place.
- Uses one shared compare-exchange unit, time-multiplexed through a fixed bubble-sort schedule.
- Returns the sorted vector, its median and a swap count on a valid/ready output port.
- Multi-cycle, area-lean replacement for the fully unrolled combinational sort network in the sort datapath.

Parameters:
- N, 5, number of elements (N >= 2; median = element N/2, integer division).
- W, 6, element width in bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input vector valid.
- in_ready  output  1  block can accept; high only in IDLE.
- in_data  input  N*W  element k at bits [k*W +: W].
- in_desc  input  1  order select, sampled with in_data: 0 ascending, 1 descending.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- out_sorted  output  N*W  sorted vector; element 0 at bits [W-1:0]; smallest first if ascending, largest first if descending.
- out_median  output  W  element N/2 of out_sorted.
- swap_cnt  output  $clog2(NUM_CMP+1)  number of exchanges performed for this vector.
- busy  output  1  high in SORT.

Behaviour:
- Reset (rst high at a clock edge):
  - state = IDLE.
  - Element registers, out_sorted, out_median, swap_cnt, pass and idx counters, desc flag all cleared to 0.
  - out_valid = 0, busy = 0. in_ready = 1 from the first edge after reset.
  - Reset wins over every other event, including mid-SORT and mid-DONE; a partial sort is discarded with no output.
- NUM_CMP = N*(N-1)/2; equals 10 for N=5.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: capture in_data and in_desc, clear swap_cnt, set pass = 0, idx = 0, go to SORT.
- SORT: one compare-exchange per cycle.
  - Operands are reg[idx] and reg[idx+1].
  - Swap only on strict inequality: reg[idx] > reg[idx+1] when ascending, reg[idx] < reg[idx+1] when descending.
  - Equal values are never swapped (stable).
  - Each swap increments swap_cnt.
  - Index sequencing: if idx == N-2-pass then idx = 0 and pass increments; otherwise idx increments.
  - After the compare at pass = N-2, idx = 0, go to DONE.
  - Exactly NUM_CMP SORT cycles, independent of data; there is no early exit.
- DONE:
  - out_valid = 1; out_sorted, out_median and swap_cnt are driven directly from registers and held stable.
  - in_ready = 0; in_valid is ignored.
  - On out_valid && out_ready: go to IDLE. out_valid falls and in_ready rises on the same edge.
  - No same-cycle accept of a new vector in DONE; minimum input-to-input spacing is NUM_CMP + 2 cycles.
- Latency: out_valid first samples high at the edge NUM_CMP + 1 edges after the accepting edge (11 for N=5).
- Outputs in IDLE/SORT:
  - out_valid = 0.
  - out_sorted and out_median keep their last DONE values (0 after reset) and may reflect in-progress registers only after entering DONE.
  - Benches check them only when out_valid = 1.
- Arithmetic: comparisons are unsigned, W bits. swap_cnt saturates by construction (max NUM_CMP).
- in_desc is latched at acceptance; later changes do not affect the sort in flight.

Decomposition:
- Package sort_pkg holds:
  - state enum (IDLE, SORT, DONE);
  - default N and W;
  - function num_cmp(N) returning N*(N-1)/2;
  - element typedef logic [W-1:0].
- Sub-module cmp_swap: purely combinational compare-exchange.
  - Inputs: a, b, desc.
  - Outputs: lo_out, hi_out, swapped.
  - Instantiated once; the FSM muxes reg[idx] and reg[idx+1] into it and writes back.

Test Plan:
- Reverse input, ascending: in_data {63,40,20,10,0} (elem0..4), in_desc=0 → out_sorted {0,10,20,40,63}, out_median 20, swap_cnt 10. out_valid first high 11 edges after accept; busy high exactly 10 cycles.
- Already sorted: {1,2,3,4,5}, ascending → out_sorted unchanged, swap_cnt 0, same 11-edge latency.
- Duplicates: {7,7,3,7,3}, ascending → {3,3,7,7,7}, out_median 7, swap_cnt 5 (equal pairs not swapped).
- Descending: {1,2,3,4,5}, in_desc=1 (in_desc toggled to 0 mid-SORT) → {5,4,3,2,1}, out_median 3, swap_cnt 10.
- Backpressure: hold out_ready=0 for 20 cycles in DONE while in_valid=1 with new data → outputs stable, in_ready=0, nothing captured. Raise out_ready → IDLE next edge, in_ready=1, second vector sorts correctly.
- Reset mid-operation: assert rst for one cycle at the 4th SORT cycle → next edge state IDLE, out_valid=0, swap_cnt=0, in_ready=1. A fresh vector then sorts with the full 11-edge latency.
